// File: rtl/ysyx_22040759_pipe_ctrl_if.sv
// Pipeline hazard bus between the core stages and the stall/flush sequencer.
// The pipeline (master) reports hazard causes; the sequencer (slave) returns
// per-register hold/bubble controls and status.
interface ysyx_22040759_pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_ren;
  logic             id_rs2_ren;
  logic [4:0]       ex_rd;
  logic             ex_memread;
  logic             ex_md_start;
  logic             md_done;
  logic             if_busy;
  logic             mem_busy;
  logic             ex_redirect;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_stall;
  logic             exmem_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_ren, id_rs2_ren, ex_rd, ex_memread,
           ex_md_start, md_done, if_busy, mem_busy, ex_redirect,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall,
           ifid_flush, idex_flush, exmem_flush, md_busy, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_ren, id_rs2_ren, ex_rd, ex_memread,
           ex_md_start, md_done, if_busy, mem_busy, ex_redirect,
    output pc_stall, ifid_stall, idex_stall, exmem_stall,
           ifid_flush, idex_flush, exmem_flush, md_busy, stall_cnt
  );
endinterface

// File: rtl/ysyx_22040759_pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Merges bus wait,
// mul/div wait, load-use, fetch wait and branch redirect into prioritised
// hold/bubble controls, tracks an in-flight mul/div and a redirect that
// landed on an outstanding fetch, and counts PC stall cycles.
module ysyx_22040759_pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_22040759_pipe_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic md_wait;
  logic load_use;
  logic redir_ok;
  logic rs1_hit;
  logic rs2_hit;

  logic pc_stall_c, ifid_stall_c, idex_stall_c, exmem_stall_c;
  logic ifid_flush_c, idex_flush_c, exmem_flush_c, md_busy_c;

  // The mul/div is blocking the pipe unless its result arrives this cycle.
  assign md_wait  = ((state_q == RUN) & bus.ex_md_start & ~bus.md_done)
                  | ((state_q == MD_WAIT) & ~bus.md_done);
  assign rs1_hit  = bus.id_rs1_ren & (bus.id_rs1 == bus.ex_rd);
  assign rs2_hit  = bus.id_rs2_ren & (bus.id_rs2 == bus.ex_rd);
  assign load_use = bus.ex_memread & (bus.ex_rd != 5'd0) & (rs1_hit | rs2_hit);
  // A redirect held in EX is only taken once nothing older is stalling.
  assign redir_ok = bus.ex_redirect & ~bus.mem_busy & ~md_wait;

  // State, pending-redirect flag and stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      redir_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Mul/div tracking FSM next state; a 1-cycle op never leaves RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.ex_md_start && !bus.mem_busy && !bus.md_done) state_d = MD_WAIT;
      MD_WAIT: if (bus.md_done) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Pending flag remembers a killed fetch whose stale instruction must be
  // dropped when it returns; counter accumulates PC stall cycles
  always_comb begin
    redir_pend_d = redir_pend_q;
    if (redir_ok && bus.if_busy) begin
      redir_pend_d = 1'b1;
    end else if (!bus.if_busy) begin
      redir_pend_d = 1'b0;
    end
    stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall_c);
  end

  // Prioritised stall/flush decode; reset forces everything low
  always_comb begin
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    idex_stall_c  = 1'b0;
    exmem_stall_c = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    md_busy_c     = 1'b0;
    if (!rst) begin
      md_busy_c = (state_q == MD_WAIT);
      if (bus.mem_busy) begin
        pc_stall_c    = 1'b1;
        ifid_stall_c  = 1'b1;
        idex_stall_c  = 1'b1;
        exmem_stall_c = 1'b1;
      end else if (md_wait) begin
        pc_stall_c    = 1'b1;
        ifid_stall_c  = 1'b1;
        idex_stall_c  = 1'b1;
        exmem_flush_c = 1'b1;
      end else if (redir_ok) begin
        ifid_flush_c  = 1'b1;
        idex_flush_c  = 1'b1;
      end else if (load_use) begin
        pc_stall_c    = 1'b1;
        ifid_stall_c  = 1'b1;
        idex_flush_c  = 1'b1;
      end else if (bus.if_busy) begin
        pc_stall_c    = 1'b1;
        ifid_flush_c  = 1'b1;
      end else if (redir_pend_q) begin
        ifid_flush_c  = 1'b1;
      end
    end
  end

  assign bus.pc_stall    = pc_stall_c;
  assign bus.ifid_stall  = ifid_stall_c;
  assign bus.idex_stall  = idex_stall_c;
  assign bus.exmem_stall = exmem_stall_c;
  assign bus.ifid_flush  = ifid_flush_c;
  assign bus.idex_flush  = idex_flush_c;
  assign bus.exmem_flush = exmem_flush_c;
  assign bus.md_busy     = md_busy_c;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
